wptr_full_afull: RTL and testbench

Write-domain pointer and status generator for a dual-clock gray-pointer FIFO of depth 2**ADDR_WIDTH.
- Produces the binary write address, the gray write pointer for the read-domain synchroniser, and registered full status.
- Adds what the basic write-pointer block lacks: conservative occupancy count, programmable almost-full threshold and optional sticky overflow detection.
- Sits between the FIFO write client, the dual-port RAM write port and the rptr→wclk 2-flop synchroniser.

---
 rtl/wptr_full_afull.sv | 81 ++++++++
 tb/tb_wptr_full_afull.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wptr_full_afull.sv
// Write-side pointer, full / almost-full and occupancy generator for a gray-pointer async FIFO.
// Define WPTR_FULL_OVF_EN to build the sticky overflow flag (wovf); otherwise wovf is tied 0.
module wptr_full_afull #(
    parameter int unsigned ADDR_WIDTH = 3
) (
    input  logic                  wclk,
    input  logic                  rst_n,
    input  logic                  winc,
    input  logic [ADDR_WIDTH:0]   rptr_sync,
    input  logic [ADDR_WIDTH:0]   afull_thresh,
    input  logic                  ovf_clr,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   wptr,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [ADDR_WIDTH:0]   wlevel,
    output logic                  wovf
);

    localparam int unsigned AW = ADDR_WIDTH;

    logic [AW:0] wbin_q;
    logic [AW:0] wbin_d;
    logic [AW:0] wgray_d;
    logic [AW:0] rbin;
    logic [AW:0] level_d;
    logic        we;
    logic        full_d;
    logic        afull_d;

    // Each binary bit is the XOR of all gray bits at or above it.
    always_comb begin
        rbin = '0;
        for (int i = 0; i <= int'(AW); i++) begin
            rbin[i] = ^(rptr_sync >> i);
        end
    end

    always_comb begin
        we      = winc & ~full;
        wbin_d  = wbin_q + {{AW{1'b0}}, we};
        wgray_d = (wbin_d >> 1) ^ wbin_d;
        level_d = wbin_d - rbin;
        full_d  = (wgray_d == {~rptr_sync[AW:AW-1], rptr_sync[AW-2:0]});
        afull_d = (level_d >= afull_thresh);
    end

    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            wbin_q      <= '0;
            wptr        <= '0;
            waddr       <= '0;
            wlevel      <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
        end else begin
            wbin_q      <= wbin_d;
            wptr        <= wgray_d;
            waddr       <= wbin_d[AW-1:0];
            wlevel      <= level_d;
            full        <= full_d;
            almost_full <= afull_d;
        end
    end

`ifdef WPTR_FULL_OVF_EN
    // Set has priority over clear so a coincident overflow is never lost.
    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            wovf <= 1'b0;
        end else begin
            wovf <= (winc & full) | (wovf & ~ovf_clr);
        end
    end
`else
    logic unused_ovf_clr;
    assign unused_ovf_clr = ovf_clr;
    assign wovf           = 1'b0;
`endif

endmodule

// File: tb/tb_wptr_full_afull.sv
// Self-checking bench for wptr_full_afull (ADDR_WIDTH=3) against a word-count model.
module tb_wptr_full_afull;

    localparam int unsigned AW    = 3;
    localparam int          DEPTH = 8;

    logic          wclk;
    logic          rst_n;
    logic          winc;
    logic [AW:0]   rptr_sync;
    logic [AW:0]   afull_thresh;
    logic          ovf_clr;
    logic          full;
    logic          almost_full;
    logic [AW:0]   wptr;
    logic [AW-1:0] waddr;
    logic [AW:0]   wlevel;
    logic          wovf;

    int checks;
    int errors;

    // Model: total accepted writes, total reads seen via rptr_sync, registered flags.
    int mwr;
    int mrd;
    bit m_af;
    bit m_ovf;
    bit ever_full;

    wptr_full_afull #(.ADDR_WIDTH(AW)) dut (
        .wclk        (wclk),
        .rst_n       (rst_n),
        .winc        (winc),
        .rptr_sync   (rptr_sync),
        .afull_thresh(afull_thresh),
        .ovf_clr     (ovf_clr),
        .full        (full),
        .almost_full (almost_full),
        .wptr        (wptr),
        .waddr       (waddr),
        .wlevel      (wlevel),
        .wovf        (wovf)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    function automatic logic [AW:0] gray(input int n);
        logic [AW:0] b;
        b = 4'(n % (2 * DEPTH));
        return b ^ (b >> 1);
    endfunction

    function automatic bit ovf_en();
`ifdef WPTR_FULL_OVF_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic do_reset();
        @(negedge wclk);
        winc      = 1'b0;
        ovf_clr   = 1'b0;
        rptr_sync = '0;
        rst_n     = 1'b0;
        mwr = 0; mrd = 0; m_af = 0; m_ovf = 0;
        @(negedge wclk);
        rst_n = 1'b1;
    endtask

    // One clock: drive at negedge, advance model, sample 1 time unit after posedge.
    task automatic tick(input logic w, input logic r, input logic c);
        bit full_prev;
        @(negedge wclk);
        full_prev = (mwr - mrd) == DEPTH;
        if (r && mrd < mwr) mrd++;
        if (w && !full_prev) mwr++;
        m_ovf = ovf_en() && ((w && full_prev) || (m_ovf && !c));
        m_af  = (mwr - mrd) >= int'(afull_thresh);
        winc      = w;
        ovf_clr   = c;
        rptr_sync = gray(mrd);
        @(posedge wclk);
        #1;
        if (full) ever_full = 1'b1;
        checks++;
        if (full !== (wlevel == 4'(DEPTH))) begin
            errors++;
            $display("FAIL invariant full=%0b wlevel=%0d", full, wlevel);
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if ({wptr, waddr, wlevel, full, almost_full, wovf} !== '0) begin
            errors++;
            $display("FAIL reset_idle got wptr=%b waddr=%0d wlevel=%0d full=%b af=%b ovf=%b",
                     wptr, waddr, wlevel, full, almost_full, wovf);
        end
        afull_thresh = 4'd2;
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 1'b0);
        checks++;
        if (wlevel !== 4'd5 || almost_full !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset got wlevel=%0d af=%b exp 5 1", wlevel, almost_full);
        end
        @(negedge wclk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({wptr, waddr, wlevel, full, almost_full, wovf} !== '0) begin
            errors++;
            $display("FAIL reset_async got wptr=%b waddr=%0d wlevel=%0d full=%b af=%b ovf=%b",
                     wptr, waddr, wlevel, full, almost_full, wovf);
        end
        do_reset();
    endtask

    task automatic test_fill();
        logic [AW:0] exp_wptr [DEPTH];
        exp_wptr = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100};
        do_reset();
        afull_thresh = 4'd15;
        for (int i = 0; i < DEPTH; i++) begin
            tick(1'b1, 1'b0, 1'b0);
            checks++;
            if (wptr !== exp_wptr[i] || waddr !== 3'((i + 1) % DEPTH)) begin
                errors++;
                $display("FAIL fill_step%0d got wptr=%b waddr=%0d exp %b %0d",
                         i, wptr, waddr, exp_wptr[i], (i + 1) % DEPTH);
            end
            checks++;
            if (full !== (i == DEPTH - 1) || wlevel !== 4'(i + 1)) begin
                errors++;
                $display("FAIL fill_status%0d got full=%b wlevel=%0d exp %b %0d",
                         i, full, wlevel, i == DEPTH - 1, i + 1);
            end
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b0, 1'b0);
            checks++;
            if (wptr !== 4'b1100 || wlevel !== 4'd8 || full !== 1'b1 || wovf !== ovf_en()) begin
                errors++;
                $display("FAIL ovf_hold%0d got wptr=%b wlevel=%0d full=%b ovf=%b exp 1100 8 1 %b",
                         i, wptr, wlevel, full, wovf, ovf_en());
            end
        end
        tick(1'b0, 1'b0, 1'b1);
        checks++;
        if (wovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear got %b exp 0", wovf);
        end
        tick(1'b1, 1'b0, 1'b1);
        checks++;
        if (wovf !== ovf_en()) begin
            errors++;
            $display("FAIL ovf_set_wins got %b exp %b", wovf, ovf_en());
        end
        tick(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_afull();
        do_reset();
        afull_thresh = 4'd6;
        for (int i = 1; i <= DEPTH; i++) begin
            tick(1'b1, 1'b0, 1'b0);
            checks++;
            if (almost_full !== (i >= 6) || wlevel !== 4'(i)) begin
                errors++;
                $display("FAIL afull6_w%0d got af=%b wlevel=%0d exp %b %0d",
                         i, almost_full, wlevel, i >= 6, i);
            end
        end
        // Read pointer advances by one gray step per cycle while full.
        for (int i = 1; i <= 2; i++) begin
            tick(1'b0, 1'b1, 1'b0);
            checks++;
            if (full !== 1'b0 || wlevel !== 4'(DEPTH - i) || almost_full !== 1'b1
                || rptr_sync !== gray(i)) begin
                errors++;
                $display("FAIL drain%0d got full=%b wlevel=%0d af=%b exp 0 %0d 1",
                         i, full, wlevel, almost_full, DEPTH - i);
            end
        end
        do_reset();
        afull_thresh = 4'd9;
        for (int i = 0; i < DEPTH + 1; i++) begin
            tick(1'b1, 1'b0, 1'b0);
            checks++;
            if (almost_full !== 1'b0) begin
                errors++;
                $display("FAIL afull9_w%0d got af=%b exp 0", i, almost_full);
            end
        end
        do_reset();
        afull_thresh = 4'd0;
        tick(1'b0, 1'b0, 1'b0);
        checks++;
        if (almost_full !== 1'b1) begin
            errors++;
            $display("FAIL afull0 got af=%b exp 1", almost_full);
        end
        do_reset();
        afull_thresh = 4'd8;
        for (int i = 0; i < 12; i++) begin
            tick(i < 9, (i >= 9), 1'b0);
            checks++;
            if (almost_full !== full) begin
                errors++;
                $display("FAIL afull8_c%0d got af=%b exp %b", i, almost_full, full);
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        afull_thresh = 4'd6;
        ever_full = 1'b0;
        for (int i = 0; i < 2 * DEPTH + 3; i++) begin
            tick(i < 2 * DEPTH, i >= 3, 1'b0);
        end
        checks++;
        if (ever_full !== 1'b0) begin
            errors++;
            $display("FAIL wrap_never_full got 1 exp 0");
        end
        checks++;
        if (wptr !== 4'b0000 || waddr !== 3'd0 || wlevel !== 4'd0) begin
            errors++;
            $display("FAIL wrap_end got wptr=%b waddr=%0d wlevel=%0d exp 0000 0 0",
                     wptr, waddr, wlevel);
        end
    endtask

    task automatic test_random();
        do_reset();
        afull_thresh = 4'($urandom_range(0, 10));
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 31) == 0) afull_thresh = 4'($urandom_range(0, 10));
            tick(1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 99) < 45),
                 1'($urandom_range(0, 9) == 0));
            checks++;
            if (wptr !== gray(mwr) || waddr !== 3'(mwr % DEPTH) || wlevel !== 4'(mwr - mrd)
                || full !== ((mwr - mrd) == DEPTH) || almost_full !== m_af
                || wovf !== m_ovf) begin
                errors++;
                $display("FAIL rand%0d got wptr=%b waddr=%0d wlevel=%0d full=%b af=%b ovf=%b exp %b %0d %0d %b %b %b",
                         i, wptr, waddr, wlevel, full, almost_full, wovf, gray(mwr),
                         mwr % DEPTH, mwr - mrd, (mwr - mrd) == DEPTH, m_af, m_ovf);
            end
        end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst_n        = 1'b0;
        winc         = 1'b0;
        ovf_clr      = 1'b0;
        rptr_sync    = '0;
        afull_thresh = 4'd6;
        ever_full    = 1'b0;
        test_reset();
        test_fill();
        test_overflow();
        test_afull();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
